// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: shares one RGB LED among prioritised requesters, shaping SOLID/BLINK/BREATHE
// envelopes, fading to dark before ownership moves, and driving three PWM channels.
`timescale 1ns/1ps
module led_pattern_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int PWM_WIDTH   = 12,
  parameter int LEVEL_MAX   = 1023,
  parameter int STEP        = 16,
  parameter int TICK_DIV    = 12000,
  parameter int BLINK_TICKS = 2000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   colour,
  input  logic [2*NUM_REQ-1:0]   mode,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic [PWM_WIDTH-1:0]   level,
  output logic                   pwm_r,
  output logic                   pwm_g,
  output logic                   pwm_b
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PWM_WIDTH:0]   LMAX       = (PWM_WIDTH+1)'(LEVEL_MAX);
  localparam logic [PWM_WIDTH-1:0] LMAX_L     = PWM_WIDTH'(LEVEL_MAX);
  localparam logic [PWM_WIDTH:0]   LSTEP      = (PWM_WIDTH+1)'(STEP);
  localparam logic [TW-1:0]        TICK_LAST  = TW'(TICK_DIV-1);
  localparam logic [BW-1:0]        BLINK_LAST = BW'(BLINK_TICKS-1);
  localparam logic [1:0]           M_BLINK    = 2'b01;
  localparam logic [1:0]           M_BREATHE  = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'b00, ACTIVE = 2'b01, SWITCH = 2'b10} state_t;

  state_t                 state, state_nx;
  logic [IW-1:0]          owner, win_idx;
  logic [NUM_REQ-1:0]     grant_nx, win_onehot;
  logic [2:0]             lat_colour, win_colour;
  logic [1:0]             lat_mode, win_mode;
  logic [PWM_WIDTH-1:0]   level_nx, pwm_ctr;
  logic [PWM_WIDTH:0]     lvl_ext, up_sum, up_sat, dn_sat;
  logic [TW-1:0]          presc;
  logic [BW-1:0]          blink_cnt, blink_cnt_nx;
  logic                   dir_down, dir_nx, blink_on, blink_on_nx;
  logic                   tick, any_req, take;

  assign tick    = (presc == TICK_LAST);
  assign any_req = |req;
  assign lvl_ext = {1'b0, level};
  assign up_sum  = lvl_ext + LSTEP;
  assign up_sat  = (up_sum >= LMAX) ? LMAX : up_sum;
  assign dn_sat  = (lvl_ext <= LSTEP) ? '0 : (lvl_ext - LSTEP);

  // Fixed-priority winner: scanning downwards leaves the lowest requesting index.
  always_comb begin
    win_idx    = '0;
    win_colour = '0;
    win_mode   = '0;
    win_onehot = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      win_idx    = req[i] ? IW'(i) : win_idx;
      win_colour = req[i] ? colour[3*i +: 3] : win_colour;
      win_mode   = req[i] ? mode[2*i +: 2] : win_mode;
      win_onehot = req[i] ? (NUM_REQ'(1'b1) << i) : win_onehot;
    end
  end

  // Next-state and envelope; take requests a fresh grant, applied in the register block.
  always_comb begin
    state_nx     = state;
    grant_nx     = grant;
    level_nx     = level;
    dir_nx       = dir_down;
    blink_on_nx  = blink_on;
    blink_cnt_nx = blink_cnt;
    take         = 1'b0;
    case (state)
      IDLE: begin
        level_nx = '0;
        if (any_req) begin
          take = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      ACTIVE: begin
        if (!req[owner] || (any_req && (win_idx < owner))) begin
          state_nx = SWITCH;
        end else if (tick) begin
          case (lat_mode)
            M_BLINK: begin
              if (blink_cnt == BLINK_LAST) begin
                blink_cnt_nx = '0;
                blink_on_nx  = ~blink_on;
                level_nx     = blink_on ? '0 : LMAX_L;
              end else begin
                blink_cnt_nx = blink_cnt + BW'(1'b1);
              end
            end
            M_BREATHE: begin
              if (dir_down) begin
                level_nx = dn_sat[PWM_WIDTH-1:0];
                dir_nx   = (dn_sat != '0);
              end else begin
                level_nx = up_sat[PWM_WIDTH-1:0];
                dir_nx   = (up_sat == LMAX);
              end
            end
            default: level_nx = level;
          endcase
        end else begin
          state_nx = ACTIVE;
        end
      end
      SWITCH: begin
        // The grant only moves on a tick that finds the fade already dark.
        if (tick) begin
          if (level != '0) begin
            level_nx = dn_sat[PWM_WIDTH-1:0];
          end else if (any_req) begin
            take = 1'b1;
          end else begin
            state_nx = IDLE;
            grant_nx = '0;
          end
        end else begin
          state_nx = SWITCH;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
        level_nx = '0;
      end
    endcase
  end

  // Prescaler and PWM carrier free-run in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      pwm_ctr <= '0;
    end else begin
      presc   <= tick ? '0 : presc + TW'(1'b1);
      pwm_ctr <= pwm_ctr + PWM_WIDTH'(1'b1);
    end
  end

  // State, envelope, latched pattern and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      grant      <= '0;
      busy       <= 1'b0;
      level      <= '0;
      dir_down   <= 1'b0;
      blink_on   <= 1'b1;
      blink_cnt  <= '0;
      lat_colour <= '0;
      lat_mode   <= '0;
      pwm_r      <= 1'b0;
      pwm_g      <= 1'b0;
      pwm_b      <= 1'b0;
    end else begin
      pwm_r <= lat_colour[2] && (pwm_ctr < level);
      pwm_g <= lat_colour[1] && (pwm_ctr < level);
      pwm_b <= lat_colour[0] && (pwm_ctr < level);
      if (take) begin
        state      <= ACTIVE;
        owner      <= win_idx;
        grant      <= win_onehot;
        busy       <= 1'b1;
        level      <= (win_mode == M_BREATHE) ? '0 : LMAX_L;
        dir_down   <= 1'b0;
        blink_on   <= 1'b1;
        blink_cnt  <= '0;
        lat_colour <= win_colour;
        lat_mode   <= win_mode;
      end else begin
        state      <= state_nx;
        grant      <= grant_nx;
        busy       <= (state_nx != IDLE);
        level      <= level_nx;
        dir_down   <= dir_nx;
        blink_on   <= blink_on_nx;
        blink_cnt  <= blink_cnt_nx;
      end
    end
  end
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: directed scenarios plus random requests, checked every clock against
// an owner/fading reference model of the shared-LED controller.
`timescale 1ns/1ps
module tb_led_pattern_ctrl;
  localparam int NR = 4, PW = 12, LMAX = 1023, STEP = 256, TDIV = 4, BT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req = 4'b0;
  logic [11:0]   colour = 12'b0;
  logic [7:0]    mode = 8'b0;
  logic [3:0]    grant;
  logic          busy;
  logic [PW-1:0] level;
  logic          pwm_r, pwm_g, pwm_b;

  int total = 0;
  int bad = 0;

  int m_owner, m_level, m_bn, m_presc, m_ctr;
  bit m_fading, m_up, m_ticked, m_pr, m_pg, m_pb;
  bit [2:0] m_col;
  bit [1:0] m_mode;

  led_pattern_ctrl #(.NUM_REQ(NR), .PWM_WIDTH(PW), .LEVEL_MAX(LMAX), .STEP(STEP),
                     .TICK_DIV(TDIV), .BLINK_TICKS(BT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .colour(colour), .mode(mode), .grant(grant),
    .busy(busy), .level(level), .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int winner(input logic [3:0] r);
    for (int i = 0; i < NR; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_fading = 0; m_level = 0; m_up = 1; m_bn = 0;
    m_presc = 0; m_ctr = 0; m_col = 3'b0; m_mode = 2'b0;
    m_pr = 0; m_pg = 0; m_pb = 0; m_ticked = 0;
  endtask

  task automatic model_take(input int w);
    m_owner = w; m_fading = 0; m_up = 1; m_bn = 0;
    m_col = colour[3*w +: 3];
    m_mode = mode[2*w +: 2];
    m_level = (m_mode == 2'b10) ? 0 : LMAX;
  endtask

  // One clock of the reference behaviour, from the inputs present before the edge.
  task automatic model_clock();
    int w;
    bit tick;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tick = (m_presc == TDIV-1);
    m_ticked = tick;
    w = winner(req);
    m_pr = m_col[2] && (m_ctr < m_level);
    m_pg = m_col[1] && (m_ctr < m_level);
    m_pb = m_col[0] && (m_ctr < m_level);
    if (m_owner < 0) begin
      if (w >= 0) model_take(w);
    end else if (!m_fading) begin
      if (!req[m_owner] || (w >= 0 && w < m_owner)) m_fading = 1;
      else if (tick) begin
        if (m_mode == 2'b01) begin
          m_bn++;
          m_level = ((m_bn / BT) % 2 == 0) ? LMAX : 0;
        end else if (m_mode == 2'b10) begin
          if (m_up) begin
            m_level = (m_level + STEP > LMAX) ? LMAX : m_level + STEP;
            m_up = (m_level != LMAX);
          end else begin
            m_level = (m_level < STEP) ? 0 : m_level - STEP;
            m_up = (m_level == 0);
          end
        end
      end
    end else if (tick) begin
      if (m_level > 0) m_level = (m_level < STEP) ? 0 : m_level - STEP;
      else if (w >= 0) model_take(w);
      else begin m_owner = -1; m_fading = 0; end
    end
    m_presc = (m_presc + 1) % TDIV;
    m_ctr = (m_ctr + 1) % (1 << PW);
  endtask

  task automatic check_all();
    check("grant", grant, (m_owner < 0) ? 0 : (1 << m_owner));
    check("busy", busy, (m_owner >= 0) ? 1 : 0);
    check("level", level, m_level);
    check("pwm_r", pwm_r, m_pr);
    check("pwm_g", pwm_g, m_pg);
    check("pwm_b", pwm_b, m_pb);
  endtask

  task automatic step();
    model_clock();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 2*TDIV; i++) begin
      step();
      if (m_ticked) return;
    end
  endtask

  initial begin
    int cnt_r, cnt_g, cnt_b;
    int breathe_exp [9] = '{256, 512, 768, 1023, 767, 511, 255, 0, 256};
    int fade_exp [3] = '{512, 256, 0};
    model_reset();
    repeat (3) step();
    #2 rst_n = 1'b1;

    // 1: solid red
    colour[2:0] = 3'b100; mode[1:0] = 2'b00; req = 4'b0001;
    step();
    check("t1_grant", grant, 4'b0001);
    check("t1_level", level, 1023);
    cnt_r = 0; cnt_g = 0; cnt_b = 0;
    for (int i = 0; i < 4096; i++) begin
      step();
      cnt_r += int'(pwm_r); cnt_g += int'(pwm_g); cnt_b += int'(pwm_b);
    end
    check("t1_r_duty", cnt_r, 1023);
    check("t1_g_duty", cnt_g, 0);
    check("t1_b_duty", cnt_b, 0);

    // 2: release, then two simultaneous requests
    req = 4'b0000;
    for (int i = 0; i < 100; i++) begin step(); if (busy === 1'b0) break; end
    check("t2_idle_grant", grant, 4'b0000);
    check("t2_idle_busy", busy, 1'b0);
    mode = 8'b0; req = 4'b1010;
    step();
    check("t2_grant", grant, 4'b0010);
    check("t2_busy", busy, 1'b1);

    // 3: owner 2 breathing green
    colour[8:6] = 3'b010; mode[5:4] = 2'b10; req = 4'b0100;
    for (int i = 0; i < 100; i++) begin step(); if (grant === 4'b0100) break; end
    check("t3_grant", grant, 4'b0100);
    check("t3_entry", level, 0);
    for (int k = 0; k < 9; k++) begin
      wait_tick();
      check($sformatf("t3_breathe%0d", k), level, breathe_exp[k]);
    end

    // 4: pre-empted at 768 by requester 0
    wait_tick(); wait_tick();
    check("t4_start", level, 768);
    colour[2:0] = 3'b001; mode[1:0] = 2'b01; req = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      wait_tick();
      check($sformatf("t4_fade%0d", k), level, fade_exp[k]);
      check($sformatf("t4_hold%0d", k), grant, 4'b0100);
    end
    wait_tick();
    check("t4_newgrant", grant, 4'b0001);
    check("t4_newlevel", level, 1023);

    // 5: drop and re-assert during fade, then drop for good
    req = 4'b0000;
    step(); wait_tick();
    check("t5_fading", level, 767);
    check("t5_busy", busy, 1'b1);
    req = 4'b0001;
    for (int i = 0; i < 60; i++) begin step(); if (level === 12'd1023) break; end
    check("t5_regrant", grant, 4'b0001);
    check("t5_fresh", level, 1023);
    req = 4'b0000;
    for (int i = 0; i < 100; i++) begin step(); if (busy === 1'b0) break; end
    check("t5_idle_grant", grant, 4'b0000);
    check("t5_idle_busy", busy, 1'b0);

    // 6: asynchronous reset mid-blink
    req = 4'b0001;
    repeat (21) step();
    #2 rst_n = 1'b0;
    #1;
    check("t6_grant", grant, 4'b0000);
    check("t6_busy", busy, 1'b0);
    check("t6_level", level, 0);
    check("t6_pwm", {pwm_r, pwm_g, pwm_b}, 3'b000);
    model_reset();
    step();
    #2 rst_n = 1'b1;
    step();
    check("t6_regrant", grant, 4'b0001);
    check("t6_rebusy", busy, 1'b1);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) begin
        colour = 12'($urandom);
        mode = 8'($urandom);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
